fifo_burst_reader: RTL

- Read-side consumer for the pre-filled async FIFO, in the FIFO's read clock domain.
- Waits for the synchronised pre-fill status, then drains a fixed-length burst from the FIFO's first-word-fall-through read port.
- Presents each burst as a valid/ready stream with a last-word marker to the convolution datapath.
- Counts underrun stalls, i.e. cycles where the FIFO runs dry mid-burst.

---
 rtl/fifo_burst_reader.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains fixed-length bursts from a pre-filled FWFT FIFO onto a valid/ready stream
// and counts the cycles where the FIFO runs dry mid-burst.
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  loop,
   input  logic                  abort,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   input  logic                  fifo_prefill_done,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  underrun,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);
   localparam int RW = $clog2(BURST_LEN + 1);
   typedef enum logic [1:0] {IDLE, ARM, STREAM, FLUSH} state_t;
   state_t                 state_q, state_d;
   logic [RW-1:0]          rem_q, rem_d;
   logic                   abort_pend_q, abort_pend_d;
   logic                   valid_q, valid_d, last_q, last_d, done_q, done_d, underrun_q, underrun_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   out_free, stall;
   always_comb begin
      out_free     = !valid_q || m_ready;
      fifo_rd_en   = (state_q == STREAM) && !abort && !fifo_empty && (rem_q != '0) && out_free;
      stall        = (state_q == STREAM) && (rem_q != '0) && fifo_empty && out_free;
      state_d      = state_q;
      rem_d        = fifo_rd_en ? rem_q - RW'(1) : rem_q;
      abort_pend_d = abort_pend_q;
      done_d       = 1'b0;
      underrun_d   = underrun_q | stall;
      cnt_d        = (stall && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
      data_d       = fifo_rd_en ? fifo_rd_data : data_q;
      valid_d      = fifo_rd_en ? 1'b1 : (m_ready ? 1'b0 : valid_q);
      last_d       = fifo_rd_en ? (rem_q == RW'(1)) : (m_ready ? 1'b0 : last_q);
      case (state_q)
         IDLE: if (start) begin
            state_d      = ARM;
            rem_d        = RW'(BURST_LEN);
            underrun_d   = 1'b0;
            cnt_d        = '0;
            abort_pend_d = 1'b0;
         end
         ARM: begin
            state_d      = abort ? FLUSH : (fifo_prefill_done ? STREAM : ARM);
            abort_pend_d = abort;
         end
         STREAM: begin
            state_d      = (abort || (fifo_rd_en && rem_q == RW'(1))) ? FLUSH : STREAM;
            abort_pend_d = abort;
         end
         FLUSH: if (out_free) begin
            // An aborted burst never re-arms and never reports done
            done_d       = !abort_pend_q;
            abort_pend_d = 1'b0;
            state_d      = (loop && !abort_pend_q) ? ARM : IDLE;
            rem_d        = (loop && !abort_pend_q) ? RW'(BURST_LEN) : rem_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rem_q        <= '0;
         abort_pend_q <= 1'b0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         abort_pend_q <= abort_pend_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         last_q       <= last_d;
         done_q       <= done_d;
         underrun_q   <= underrun_d;
         cnt_q        <= cnt_d;
      end
   end
   assign m_valid   = valid_q;
   assign m_data    = data_q;
   assign m_last    = last_q;
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign underrun  = underrun_q;
   assign stall_cnt = cnt_q;
endmodule
